// File: rtl/pe_phase_rand_lfsr_pkg.sv
// Shared types and helpers for the multi-channel PE phase randomiser.
// Mode/state encodings, the Galois polynomial, the LFSR step and per-channel seed derivation.
package pe_phase_rand_lfsr_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_RAND   = 2'b01,
    MODE_DWELL  = 2'b10,
    MODE_FREEZE = 2'b11
  } phase_rand_mode_e;

  typedef enum logic {
    S_WARM = 1'b0,
    S_RUN  = 1'b1
  } phase_rand_state_e;

  localparam logic [31:0] PHASE_RAND_POLY = 32'h8020_0003;

  // Right-shift Galois step; a non-zero state never maps to zero.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? PHASE_RAND_POLY : 32'h0);
  endfunction

  // Rotate-left by channel index so channels start decorrelated; zero is remapped to 1.
  function automatic logic [31:0] chseed(input logic [31:0] s, input int unsigned i);
    logic [63:0] w;
    logic [31:0] r;
    w = {s, s} << (i % 32);
    r = w[63:32];
    return (r == 32'h0) ? 32'h1 : r;
  endfunction

endpackage

// File: rtl/pe_phase_rand_lfsr_lfsr32.sv
// 32-bit Galois LFSR for one phase channel.
// Asynchronous reset to SEED; a load takes priority over a step.
module phase_lfsr32
  import pe_phase_rand_lfsr_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        step,
  output logic [31:0] state
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SEED;
    end else if (load) begin
      state <= (load_val == 32'h0) ? 32'h1 : load_val;
    end else if (step) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/pe_phase_rand_lfsr.sv
// Multi-channel PE phase randomiser: one LFSR per channel, seeding with warm-up, PASS/RAND/DWELL/FREEZE.
// Optional macro PHASE_RAND_STATS_EN adds the rand_count issue counter output.
module pe_phase_rand_lfsr
  import pe_phase_rand_lfsr_pkg::*;
#(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned PHASE_W      = 8,
  parameter int unsigned DWELL        = 4,
  parameter int unsigned WARMUP       = 8,
  parameter logic [31:0] SEED_DEFAULT = 32'h0000_0001
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ena,
  input  logic [1:0]              mode,
  input  logic [N_CH*PHASE_W-1:0] in_self_phase,
  input  logic                    seed_valid,
  output logic                    seed_ready,
  input  logic [31:0]             seed,
  output logic [N_CH*PHASE_W-1:0] self_phase_rand,
  output logic                    phase_valid
`ifdef PHASE_RAND_STATS_EN
  ,
  output logic [31:0]             rand_count
`endif
);

  localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned WU_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam phase_rand_state_e S_INIT = (WARMUP == 0) ? S_RUN : S_WARM;

  phase_rand_state_e state, state_nxt;
  phase_rand_mode_e  mode_e;
  logic [DW_W-1:0]   dwell_cnt, dwell_cnt_nxt;
  logic [WU_W-1:0]   warm_cnt, warm_cnt_nxt;
  logic              run, accept, pass, issue, step_en;
  logic [31:0]       lfsr_q   [N_CH];
  logic [31:0]       lfsr_nxt [N_CH];
  logic [N_CH*PHASE_W-1:0] out_nxt;

  assign mode_e = phase_rand_mode_e'(mode);

  // phase_valid is a registered copy of "state is S_RUN", so it also gates seed acceptance.
  assign seed_ready = phase_valid;

  always_comb begin
    run     = (state == S_RUN);
    accept  = seed_valid & seed_ready;
    pass    = !ena || (mode_e == MODE_PASS);
    issue   = run && ena &&
              ((mode_e == MODE_RAND) || ((mode_e == MODE_DWELL) && (dwell_cnt == '0)));
    step_en = !run || issue;
  end

  always_comb begin
    state_nxt    = state;
    warm_cnt_nxt = warm_cnt;
    if (!run) begin
      if (warm_cnt == WU_W'(WARMUP - 1)) begin
        state_nxt    = S_RUN;
        warm_cnt_nxt = '0;
      end else begin
        warm_cnt_nxt = warm_cnt + 1'b1;
      end
    end else if (accept) begin
      state_nxt    = S_INIT;
      warm_cnt_nxt = '0;
    end
  end

  // Counter is held at zero outside an enabled DWELL, so entering DWELL issues at once.
  always_comb begin
    dwell_cnt_nxt = '0;
    if (run && ena && (mode_e == MODE_DWELL)) begin
      dwell_cnt_nxt = (dwell_cnt == DW_W'(DWELL - 1)) ? '0 : dwell_cnt + 1'b1;
    end
  end

  always_comb begin
    out_nxt = self_phase_rand;
    for (int unsigned c = 0; c < N_CH; c++) begin
      lfsr_nxt[c] = lfsr_step(lfsr_q[c]);
      if (run) begin
        if (pass) begin
          out_nxt[c*PHASE_W +: PHASE_W] = in_self_phase[c*PHASE_W +: PHASE_W];
        end else if (issue) begin
          out_nxt[c*PHASE_W +: PHASE_W] = lfsr_nxt[c][PHASE_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_INIT;
      warm_cnt        <= '0;
      dwell_cnt       <= '0;
      self_phase_rand <= '0;
      phase_valid     <= 1'b0;
    end else begin
      state           <= state_nxt;
      warm_cnt        <= warm_cnt_nxt;
      dwell_cnt       <= dwell_cnt_nxt;
      self_phase_rand <= out_nxt;
      phase_valid     <= (state_nxt == S_RUN);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    phase_lfsr32 #(
      .SEED(chseed(SEED_DEFAULT, g))
    ) u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .load    (accept),
      .load_val(chseed(seed, g)),
      .step    (step_en),
      .state   (lfsr_q[g])
    );
  end

`ifdef PHASE_RAND_STATS_EN
  // An accept edge loads rather than steps, so it only clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rand_count <= '0;
    end else if (accept) begin
      rand_count <= '0;
    end else if (issue && (rand_count != '1)) begin
      rand_count <= rand_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_phase_rand_lfsr.sv
// Directed bench: single-channel instance (no warm-up) and four-channel instance (3-step warm-up, 32-bit phases).
module tb_pe_phase_rand_lfsr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        a_reset, a_ena, a_seed_valid, a_seed_ready, a_pv;
  logic [1:0]  a_mode;
  logic [7:0]  a_in, a_out;
  logic [31:0] a_seed;

  logic         b_reset, b_ena, b_seed_valid, b_seed_ready, b_pv;
  logic [1:0]   b_mode;
  logic [127:0] b_in, b_out;
  logic [31:0]  b_seed;

`ifdef PHASE_RAND_STATS_EN
  logic [31:0] a_cnt, b_cnt;
`endif

  logic [31:0] m [4];

  pe_phase_rand_lfsr #(
    .N_CH(1), .PHASE_W(8), .DWELL(4), .WARMUP(0), .SEED_DEFAULT(32'h0000_0001)
  ) dut_a (
    .clk(clk), .reset(a_reset), .ena(a_ena), .mode(a_mode), .in_self_phase(a_in),
    .seed_valid(a_seed_valid), .seed_ready(a_seed_ready), .seed(a_seed),
    .self_phase_rand(a_out), .phase_valid(a_pv)
`ifdef PHASE_RAND_STATS_EN
    , .rand_count(a_cnt)
`endif
  );

  pe_phase_rand_lfsr #(
    .N_CH(4), .PHASE_W(32), .DWELL(4), .WARMUP(3), .SEED_DEFAULT(32'h0000_0001)
  ) dut_b (
    .clk(clk), .reset(b_reset), .ena(b_ena), .mode(b_mode), .in_self_phase(b_in),
    .seed_valid(b_seed_valid), .seed_ready(b_seed_ready), .seed(b_seed),
    .self_phase_rand(b_out), .phase_valid(b_pv)
`ifdef PHASE_RAND_STATS_EN
    , .rand_count(b_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lstep(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic mstep(input int n);
    for (int c = 0; c < 4; c++)
      repeat (n) m[c] = lstep(m[c]);
  endtask

  function automatic logic [127:0] mvec();
    logic [127:0] v;
    for (int c = 0; c < 4; c++) v[c*32 +: 32] = m[c];
    return v;
  endfunction

  initial begin
    a_reset = 1'b1; a_ena = 1'b1; a_mode = 2'b01; a_in = 8'h00; a_seed_valid = 1'b0; a_seed = '0;
    b_reset = 1'b1; b_ena = 1'b1; b_mode = 2'b01; b_in = '0;    b_seed_valid = 1'b0; b_seed = '0;
    #12;
    chk("a_reset_out", a_out, 8'h00);
    chk("a_reset_valid", a_pv, 1'b0);
    chk("b_reset_out", b_out, 128'h0);
    chk("b_reset_ready", b_seed_ready, 1'b0);

    // Instance A: WARMUP=0, straight into RAND
    a_reset = 1'b0;
    tick(1);
    chk("a_rand0", a_out, 8'h03);
    chk("a_valid", a_pv, 1'b1);
    chk("a_ready", a_seed_ready, 1'b1);
    tick(1);
    chk("a_rand1", a_out, 8'h02);
    a_ena = 1'b0; a_in = 8'h5A;
    tick(1);
    chk("a_ena_off_pass", a_out, 8'h5A);
    a_ena = 1'b1;
    tick(1);
    chk("a_rand_resume", a_out, 8'h01);
    tick(1);
    chk("a_rand4", a_out, 8'h03);

    a_mode = 2'b10;
    tick(1);
    chk("a_dwell_c0", a_out, 8'h02);
    tick(3);
    chk("a_dwell_c3_hold", a_out, 8'h02);
    tick(1);
    chk("a_dwell_c4", a_out, 8'h01);
    tick(1);
    a_mode = 2'b11;
    tick(3);
    chk("a_freeze_c8", a_out, 8'h01);
    tick(1);
    chk("a_freeze_c9", a_out, 8'h01);
    a_mode = 2'b01;
    tick(1);
    chk("a_rand_after_freeze", a_out, 8'h03);
    a_mode = 2'b10;
    tick(1);
    chk("a_dwell_reentry", a_out, 8'h02);
    tick(1);
    chk("a_dwell_reentry_hold", a_out, 8'h02);
    a_mode = 2'b00; a_in = 8'hA5;
    tick(1);
    chk("a_mode_pass", a_out, 8'hA5);

    // Seed accept with WARMUP=0: accept-edge output uses the old LFSR
    a_mode = 2'b01; a_seed = 32'h8000_0001; a_seed_valid = 1'b1;
    tick(1);
    a_seed_valid = 1'b0;
    chk("a_accept_edge", a_out, 8'h01);
    chk("a_accept_valid", a_pv, 1'b1);
`ifdef PHASE_RAND_STATS_EN
    chk("a_cnt_cleared", a_cnt, 32'd0);
`endif
    tick(1); chk("a_seeded_r1", a_out, 8'h03);
    tick(1); chk("a_seeded_r2", a_out, 8'h02);
    tick(1); chk("a_seeded_r3", a_out, 8'h01);
    tick(1); chk("a_seeded_r4", a_out, 8'h03);
    tick(1); chk("a_seeded_r5", a_out, 8'h02);
`ifdef PHASE_RAND_STATS_EN
    chk("a_cnt_5", a_cnt, 32'd5);
    a_seed = 32'h0000_00FF; a_seed_valid = 1'b1;
    tick(1);
    a_seed_valid = 1'b0;
    chk("a_cnt_accept_clear", a_cnt, 32'd0);
`endif

    // Instance B: WARMUP=3, four channels
    @(negedge clk);
    b_reset = 1'b0;
    tick(1);
    chk("b_warm1_valid", b_pv, 1'b0);
    chk("b_warm1_ready", b_seed_ready, 1'b0);
    chk("b_warm1_out", b_out, 128'h0);
    tick(1);
    chk("b_warm2_valid", b_pv, 1'b0);
    tick(1);
    chk("b_warm3_valid", b_pv, 1'b1);
    chk("b_warm3_ready", b_seed_ready, 1'b1);
    chk("b_warm3_out_hold", b_out, 128'h0);
    for (int c = 0; c < 4; c++) m[c] = 32'h1 << c;
    mstep(4);
    tick(1);
    chk("b_first_rand", b_out, mvec());
    chk("b_first_rand_ch0", b_out[31:0], 32'hB02C_0003);

    // Zero seed: every channel falls back to 1; offers during warm-up are ignored
    b_seed = 32'h0; b_seed_valid = 1'b1;
    mstep(1);
    tick(1);
    b_seed = 32'hFFFF_0000;
    chk("b_seed0_accept_edge", b_out, mvec());
    chk("b_seed0_valid_low", b_pv, 1'b0);
    chk("b_seed0_ready_low", b_seed_ready, 1'b0);
    tick(1);
    chk("b_seed0_warm_hold", b_out, mvec());
    tick(1);
    chk("b_seed0_warm2_valid", b_pv, 1'b0);
    tick(1);
    chk("b_seed0_warm3_valid", b_pv, 1'b1);
    b_seed_valid = 1'b0;
    tick(1);
    chk("b_seed0_first_rand", b_out, {4{32'hB02C_0003}});

    b_seed = 32'h8000_0001; b_seed_valid = 1'b1;
    tick(1);
    b_seed_valid = 1'b0;
    chk("b_rot_accept_edge", b_out, {4{32'hD836_0002}});
    tick(3);
    chk("b_rot_warm_done", b_pv, 1'b1);
    tick(1);
    chk("b_rot_first_rand", b_out, {32'h4010_0001, 32'hA028_0003, 32'hD034_0002, 32'hB82C_0003});
    chk("b_rot_distinct",
        (b_out[31:0] != b_out[63:32]) && (b_out[31:0] != b_out[95:64]) &&
        (b_out[31:0] != b_out[127:96]) && (b_out[63:32] != b_out[95:64]) &&
        (b_out[63:32] != b_out[127:96]) && (b_out[95:64] != b_out[127:96]), 1'b1);

    // Asynchronous reset between edges while warming
    b_seed = 32'h1234_5678; b_seed_valid = 1'b1;
    tick(1);
    b_seed_valid = 1'b0;
    chk("b_prereset_warm", b_pv, 1'b0);
    #3;
    b_reset = 1'b1;
    #1;
    chk("b_async_reset_out", b_out, 128'h0);
    chk("b_async_reset_valid", b_pv, 1'b0);
`ifdef PHASE_RAND_STATS_EN
    chk("b_async_reset_cnt", b_cnt, 32'd0);
`endif
    #10;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_phase_rand_lfsr.md
Name: pe_phase_rand_lfsr

Overview:
- Multi-channel successor to the single-PE phase randomiser; feeds PE phase inputs in the DRACO array.
- Replaces non-synthesisable `$random` with one 32-bit Galois LFSR per channel.
- Adds run-time seeding with a warm-up sequence, four operating modes, dwell-time hold and a valid flag.
- Reset drives defined zeros, never X.

Parameters:
- N_CH, 4, number of PE channels served.
- PHASE_W, 8, phase width per channel; must be 1..32.
- DWELL, 4, cycles each random value is held in DWELL mode; must be ≥1.
- WARMUP, 8, LFSR advances after a seed load before output is valid; 0 allowed.
- SEED_DEFAULT, 32'h0000_0001, seed loaded at reset.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ena  in  1  0 = pass-through for all channels, whatever the mode.
- mode  in  2  phase_rand_mode_e: 00 PASS, 01 RAND, 10 DWELL, 11 FREEZE.
- in_self_phase  in  N_CH×PHASE_W  per-channel self phase.
- seed_valid  in  1  seed offer.
- seed_ready  out  1  seed accepted when valid & ready.
- seed  in  32  new seed.
- self_phase_rand  out  N_CH×PHASE_W  registered per-channel phase.
- phase_valid  out  1  high in S_RUN.

Behaviour:
- Reset is asynchronous.
  - Outputs go to 0; phase_valid = 0.
  - Dwell counter = 0; warm counter = 0.
  - Each LFSR[i] = chseed(SEED_DEFAULT, i).
  - State = S_WARM, or S_RUN if WARMUP = 0.
- Per-channel seed: chseed(s, i) = rotl32(s, i); if the result is 0, use 32'h1. The LFSR never holds 0.
- LFSR step is right-shift Galois: next = (s>>1) ^ (s[0] ? 32'h8020_0003 : 0).
- FSM:
  - S_WARM: every LFSR steps once per cycle. After WARMUP steps → S_RUN. Outputs hold their value; phase_valid = 0; seed_ready = 0.
  - S_RUN: seed_ready = 1; phase_valid = 1.
  - Seed accept (seed_valid & seed_ready): LFSRs load chseed(seed, i) on that edge; warm counter cleared; → S_WARM, or stay in S_RUN if WARMUP = 0. The outputs on the accept edge follow the normal S_RUN rule but use the pre-load LFSR values.
- S_RUN output update, registered, 1-cycle latency:
  - ena = 0, or mode PASS: out[i] ← in_self_phase[i]. LFSR holds.
  - RAND: LFSR[i] steps every cycle; out[i] ← low PHASE_W bits of the new state.
  - DWELL:
    - Issue (step + update) when the dwell counter = 0; the counter counts 0..DWELL-1 and wraps.
    - Entering DWELL from any other mode, or from ena = 0, forces the counter to 0, so the issue is immediate.
    - DWELL = 1 behaves as RAND.
  - FREEZE: out and LFSR hold.
- A mode change takes effect on the next edge. The dwell counter is cleared whenever not in DWELL.
- All channels update simultaneously.

Optional Feature:
- Macro: PHASE_RAND_STATS_EN.
- Defined:
  - Extra output rand_count (32) counts random issue events (edges on which the LFSRs step in S_RUN).
  - Saturates at 32'hFFFF_FFFF; cleared by reset and by seed accept.
  - Warm-up steps are not counted.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- In common_pkg_Script:
  - phase_rand_mode_e enum.
  - PHASE_RAND_POLY = 32'h8020_0003.
  - phase_rand_state_e {S_WARM, S_RUN}.
  - Function chseed.
- Sub-module phase_lfsr32: clk, reset, load, load_val, step, state. Async reset to its parameter seed. Load has priority over step. Instantiated N_CH times.

Test Plan:
- N_CH = 1, PHASE_W = 8, WARMUP = 0, SEED_DEFAULT = 1. Release reset, ena = 1, mode RAND → phase_valid = 1; outputs 8'h03 then 8'h02 (states 0x80200003, 0xC0300002).
- ena = 0, in_self_phase = 8'h5A → output 8'h5A next cycle. Re-enable RAND → continues the LFSR sequence from where it stopped (no skipped values).
- mode DWELL, DWELL = 4, starting from RAND → new value at cycles 0, 4, 8. Switching to FREEZE at cycle 6 → output holds value B indefinitely.
- WARMUP = 3, seed = 0 accepted → seed_ready and phase_valid low for 3 cycles; LFSR = 3 steps from 0x1. First RAND output = low bits of the 4th step.
- N_CH = 4, seed 32'h8000_0001 → channel seeds 0x80000001, 0x00000003, 0x00000006, 0x0000000C; the channels' first RAND outputs differ.
- Reset asserted mid-warm (async, between edges) → outputs 0 and phase_valid 0 immediately. With PHASE_RAND_STATS_EN, 5 RAND cycles → rand_count = 5; seed accept → 0.
